sram_uart_tx_interface: RTL and testbench
=========================================

// Module: sram_uart_tx_interface
// PURPOSE
//  Streams a block of 16-bit words out of external SRAM over the UART TX pin (8N1, LSB first).
//  It is the transmit counterpart of the UART_SRAM_interface receive path.
//  The top level grants it the SRAM port in a dedicated top state and drives UART_TX_O from it.
//  Each word is sent high byte first, then low byte, mirroring the receive-side byte packing.
// PARAMETERS
//  CLK_PER_BIT   434  clock cycles per UART bit (50 MHz / 115200 baud)
//  READ_LATENCY  2    cycles from SRAM_address valid to SRAM_read_data valid
// PORTS
//  Clock           in   1   50 MHz system clock
//  Resetn          in   1   asynchronous, active-low reset
//  Start           in   1   one-cycle request; sampled only in S_IDLE
//  Start_address   in   18  first SRAM word address; sampled with Start
//  Word_count      in   18  number of words to send; sampled with Start; 0 is legal
//  SRAM_address    out  18  SRAM read address
//  SRAM_read_data  in   16  SRAM read data, valid READ_LATENCY cycles after the address
//  SRAM_we_n       out  1   SRAM write enable; constant 1 (this block only reads)
//  UART_TX_O       out  1   serial line; idle high
//  Busy            out  1   high from the cycle after Start accept to the Done cycle
//  Done            out  1   one-cycle pulse when the transfer completes
// BEHAVIOUR
//  Reset values: SRAM_address=0, SRAM_we_n=1, UART_TX_O=1, Busy=0, Done=0, state=S_IDLE.
//  Counters and buffers are all cleared by reset.
//  States: S_IDLE, S_FETCH, S_TX_HI, S_TX_LO, S_DONE.
//  S_IDLE:
//   - Start=1 at edge k: latch address and count; Busy=1 from k+1.
//   - Start=1 with Word_count=0: go to S_DONE; Done pulses at k+1; no TX activity.
//   - Start=1 with Word_count!=0: go to S_FETCH; SRAM_address=Start_address from k+1.
//  S_FETCH:
//   - Wait READ_LATENCY cycles, then capture SRAM_read_data into the word buffer.
//   - Go to S_TX_HI; the start bit begins the cycle after capture.
//  Frame format:
//   - start bit 0, data[0..7], stop bit 1.
//   - Each bit holds exactly CLK_PER_BIT cycles, counted by an internal bit-timer.
//   - A frame lasts 10*CLK_PER_BIT cycles.
//  S_TX_HI: sends buffer[15:8], then goes to S_TX_LO with no gap.
//  S_TX_LO:
//   - Sends buffer[7:0].
//   - On entry, if words remain: SRAM_address advances by 1, modulo 2^18 (3FFFF wraps to 00000).
//   - Next word is prefetched into a second buffer within READ_LATENCY cycles.
//  After the LO stop bit:
//   - If remaining count != 0: move the prefetch buffer to the word buffer; start bit of the next HI follows immediately.
//   - Otherwise go to S_DONE.
//   - A word stream is therefore gap-free: 20*CLK_PER_BIT cycles per word.
//  S_DONE: Done=1 and Busy=0 for one cycle, then S_IDLE.
//  Start is ignored while Busy=1, including in the S_DONE cycle.
//  UART_TX_O is registered and glitch-free; it is 1 in S_IDLE, S_FETCH and S_DONE.
//  Remaining count decrements once per word, when its LO byte begins.
//  Reset mid-transfer:
//   - UART_TX_O returns to 1 asynchronously; Busy=0; Done is never pulsed.
//   - A partial frame is truncated; the next Start restarts cleanly.
//  Arithmetic: count and address are 18-bit unsigned; no overflow flag.
// TESTING (bench uses CLK_PER_BIT=4, READ_LATENCY=2, SRAM model with 2-cycle latency)
//  T1 single word:
//   - SRAM[100]=A55A; Start, addr=100, count=1.
//   - UART_TX_O shows 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1.
//   - Each bit lasts 4 cycles; Done exactly 80 cycles after the first start bit edge.
//  T2 zero count: Start with count=0 -> Done at k+1; Busy high zero cycles after k+1; UART_TX_O stays 1.
//  T3 wrap and back-to-back:
//   - addr=3FFFF, count=2, SRAM[3FFFF]=1234, SRAM[0]=5678.
//   - Bytes 12,34,56,78 appear contiguously with no idle bit (160 cycles).
//   - SRAM_address sequence is 3FFFF then 00000.
//  T4 Start while busy: pulse Start (count=5) mid-T1 -> ignored; only the T1 word is sent; one Done.
//  T5 reset mid-frame:
//   - Assert Resetn=0 during data bit 3 of the HI byte.
//   - UART_TX_O=1 and Busy=0 immediately.
//   - A new Start then produces a full correct frame.
//  T6 SRAM_we_n: stays 1 in every cycle of T1-T5; checked by assertion.

Source files
------------

// File: rtl/sram_uart_tx_interface.sv
`default_nettype none
// ============================================================================
// Module   : sram_uart_tx_interface
// Purpose  : Reads a block of 16-bit words from external SRAM and sends them
//            on the UART TX line (8N1, LSB first), high byte then low byte.
//            Words stream back-to-back with no idle bits between frames.
//            The next word is prefetched into a second buffer while the
//            current low byte is being shifted out.
// Ports    : Clock          - system clock
//            Resetn         - asynchronous active-low reset
//            Start          - one-cycle request, sampled only when idle
//            Start_address  - first SRAM word address (sampled with Start)
//            Word_count     - number of words to send (0 is legal)
//            SRAM_address   - SRAM read address
//            SRAM_read_data - SRAM read data, READ_LATENCY cycles after address
//            SRAM_we_n      - SRAM write enable, tied inactive (read only)
//            UART_TX_O      - registered serial output, idle high
//            Busy           - transfer in progress (excludes the Done cycle)
//            Done           - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module sram_uart_tx_interface #(
  parameter int CLK_PER_BIT  = 434,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam int            BW            = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int            LW            = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST      = BW'(CLK_PER_BIT - 1);
  localparam logic [LW-1:0] LAT_LAST      = LW'(READ_LATENCY);
  localparam logic [3:0]    IDX_LAST_DATA = 4'd8;
  localparam logic [3:0]    IDX_STOP      = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_TX_HI = 3'd2,
    S_TX_LO = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state;
  state_t         next_state;

  logic [17:0]    addr;
  logic [17:0]    remaining;
  logic [15:0]    word_buf;
  logic [15:0]    next_buf;
  logic [LW-1:0]  lat_cnt;
  logic           pf_active;
  logic [BW-1:0]  bit_cnt;
  logic [3:0]     bit_idx;      // 0 = start bit, 1..8 = data, 9 = stop bit
  logic           tx;

  logic           lat_done;
  logic           tx_state;
  logic           frame_end;
  logic           lo_entry;
  logic           more_words;
  logic [7:0]     cur_byte;

  assign lat_done  = (lat_cnt == LAT_LAST);
  assign tx_state  = (state == S_TX_HI) || (state == S_TX_LO);
  assign frame_end = tx_state && (bit_cnt == BIT_LAST) && (bit_idx == IDX_STOP);
  assign lo_entry  = (state == S_TX_HI) && frame_end;
  // Evaluated at lo_entry, before the decrement: another word follows this one.
  assign more_words = (remaining != 18'd1);
  assign cur_byte   = (state == S_TX_HI) ? word_buf[15:8] : word_buf[7:0];

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          next_state = (Word_count == 18'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        Busy = 1'b1;
        if (lat_done) begin
          next_state = S_TX_HI;
        end
      end
      S_TX_HI: begin
        Busy = 1'b1;
        if (frame_end) begin
          next_state = S_TX_LO;
        end
      end
      S_TX_LO: begin
        Busy = 1'b1;
        if (frame_end) begin
          // remaining was already decremented when this low byte began
          next_state = (remaining != 18'd0) ? S_TX_HI : S_DONE;
        end
      end
      S_DONE: begin
        Done       = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address and word counter
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      addr      <= '0;
      remaining <= '0;
    end else if ((state == S_IDLE) && Start) begin
      addr      <= Start_address;
      remaining <= Word_count;
    end else if (lo_entry) begin
      remaining <= remaining - 18'd1;
      if (more_words) begin
        addr <= addr + 18'd1;   // natural 18-bit wrap
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read latency counter, word buffer and prefetch buffer.
  // The initial fetch and the prefetch never overlap, so they share lat_cnt.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      lat_cnt   <= '0;
      pf_active <= 1'b0;
      word_buf  <= '0;
      next_buf  <= '0;
    end else begin
      if ((state == S_IDLE) && Start) begin
        lat_cnt   <= '0;
        pf_active <= 1'b0;
      end else if (state == S_FETCH) begin
        if (lat_done) begin
          word_buf <= SRAM_read_data;
        end else begin
          lat_cnt <= lat_cnt + LW'(1);
        end
      end else if (lo_entry && more_words) begin
        lat_cnt   <= '0;
        pf_active <= 1'b1;
      end else if (pf_active) begin
        if (lat_done) begin
          next_buf  <= SRAM_read_data;
          pf_active <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt + LW'(1);
        end
      end

      if ((state == S_TX_LO) && frame_end && (remaining != 18'd0)) begin
        word_buf <= next_buf;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bit timer and serial output register. The register is loaded with the
  // level of the upcoming bit at each bit boundary, so the pin never glitches.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tx      <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else if ((state == S_FETCH) && lat_done) begin
      tx      <= 1'b0;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else if (tx_state) begin
      if (bit_cnt != BIT_LAST) begin
        bit_cnt <= bit_cnt + BW'(1);
      end else begin
        bit_cnt <= '0;
        if (bit_idx == IDX_STOP) begin
          // back-to-back frames start immediately; otherwise return to idle
          bit_idx <= '0;
          tx      <= (next_state == S_DONE);
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= (bit_idx == IDX_LAST_DATA) ? 1'b1 : cur_byte[bit_idx[2:0]];
        end
      end
    end else begin
      tx <= 1'b1;
    end
  end

  assign SRAM_address = addr;
  assign SRAM_we_n    = 1'b1;
  assign UART_TX_O    = tx;

endmodule
`default_nettype wire

// File: tb/tb_sram_uart_tx_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_uart_tx_interface
// Purpose  : Self-checking bench for sram_uart_tx_interface with a 2-cycle
//            SRAM model. Directed vectors come from a table; randomized
//            transfers are checked against a byte-stream reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_uart_tx_interface;

  localparam int CPB = 4;
  localparam int RL  = 2;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Start;
  logic [17:0] Start_address;
  logic [17:0] Word_count;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  sram_uart_tx_interface #(
    .CLK_PER_BIT  (CPB),
    .READ_LATENCY (RL)
  ) dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .Start          (Start),
    .Start_address  (Start_address),
    .Word_count     (Word_count),
    .SRAM_address   (SRAM_address),
    .SRAM_read_data (SRAM_read_data),
    .SRAM_we_n      (SRAM_we_n),
    .UART_TX_O      (UART_TX_O),
    .Busy           (Busy),
    .Done           (Done)
  );

  // SRAM model: data for the address seen in one cycle appears two cycles later
  logic [15:0] mem [0:262143];
  logic [15:0] p1, p2;
  always @(posedge Clock) begin
    p1 <= mem[SRAM_address];
    p2 <= p1;
  end
  assign SRAM_read_data = p2;

  // Write enable must never be asserted
  always @(negedge Clock) begin
    checks++;
    assert (SRAM_we_n === 1'b1) else begin
      errors++;
      $display("FAIL sram_we_n: got %b required 1", SRAM_we_n);
    end
  end

  // Expected byte stream and address sequence for the transfer under test
  logic [7:0]  exp_q[$];
  logic [17:0] exp_addr_q[$];

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  // Reference model: words are read at consecutive 18-bit addresses, high byte first
  task automatic build_model(input logic [17:0] a, input int n);
    logic [17:0] ad;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < n; i++) begin
      ad = a + 18'(i);
      exp_addr_q.push_back(ad);
      exp_q.push_back(mem[ad][15:8]);
      exp_q.push_back(mem[ad][7:0]);
    end
  endtask

  // Issue Start, record every cycle of the transfer, then compare to exp_q
  task automatic run_xfer(input logic [17:0] a, input logic [17:0] n, input bit noise,
                          input int exp_len, input int id);
    bit          tx_log[$];
    bit          busy_log[$];
    bit          done_log[$];
    logic [17:0] addr_log[$];
    logic [17:0] aseq[$];
    logic [7:0]  got;
    int          len, f, done_at, done_exp, ndone, bad, idx;
    bit          eb;

    len = RL + 1 + exp_len + 25;
    @(negedge Clock);
    Start = 1'b1; Start_address = a; Word_count = n;
    @(negedge Clock);
    Start = 1'b0; Start_address = 18'($urandom); Word_count = 18'($urandom);
    for (int c = 0; c < len; c++) begin
      tx_log.push_back(UART_TX_O);
      busy_log.push_back(Busy);
      done_log.push_back(Done);
      addr_log.push_back(SRAM_address);
      if (noise) begin
        // a request mid-frame and one during the Done cycle must both be ignored
        Start         = (c == 20) || (Done === 1'b1);
        Start_address = 18'h00300;
        Word_count    = 18'd5;
      end
      @(negedge Clock);
    end
    Start = 1'b0;

    f = -1;
    for (int i = 0; i < len; i++) if (f < 0 && tx_log[i] == 1'b0) f = i;

    if (n == 18'd0) begin
      chk($sformatf("v%0d_no_tx_activity", id), f, -1);
      done_exp = 0;
    end else begin
      chk($sformatf("v%0d_start_latency", id), f, RL + 1);
      done_exp = (f >= 0) ? f + exp_len : len;
      if (f >= 0) begin
        for (int b = 0; b < exp_q.size(); b++) begin
          bad = 0;
          got = '0;
          for (int j = 0; j < 10; j++) begin
            eb = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_q[b][j-1];
            for (int s = 0; s < CPB; s++) begin
              idx = f + b*10*CPB + j*CPB + s;
              if (idx >= len || tx_log[idx] != eb) bad++;
            end
          end
          for (int k = 0; k < 8; k++) begin
            idx = f + b*10*CPB + (k+1)*CPB + CPB/2;
            if (idx < len) got[k] = tx_log[idx];
          end
          checks++;
          if (bad != 0) begin
            errors++;
            $display("FAIL v%0d_byte%0d: got 0x%02h (%0d bad cycles) required 0x%02h",
                     id, b, got, bad, exp_q[b]);
          end
        end
      end
    end

    bad = 0;
    for (int i = 0; i < len; i++) begin
      if ((n == 18'd0 || i < f || i >= f + exp_len) && tx_log[i] != 1'b1) bad++;
    end
    chk($sformatf("v%0d_line_idle_cycles_low", id), bad, 0);

    done_at = -1;
    ndone   = 0;
    for (int i = 0; i < len; i++) begin
      if (done_log[i]) begin
        if (done_at < 0) done_at = i;
        ndone++;
      end
    end
    chk($sformatf("v%0d_done_cycle", id), done_at, done_exp);
    chk($sformatf("v%0d_done_pulses", id), ndone, 1);

    bad = 0;
    for (int i = 0; i < len; i++) if (busy_log[i] != (i < done_exp)) bad++;
    chk($sformatf("v%0d_busy_bad_cycles", id), bad, 0);

    if (n != 18'd0) begin
      for (int i = 0; i < done_exp && i < len; i++) begin
        if (aseq.size() == 0 || aseq[$] != addr_log[i]) aseq.push_back(addr_log[i]);
      end
      chk($sformatf("v%0d_addr_seq_len", id), aseq.size(), exp_addr_q.size());
      for (int i = 0; i < aseq.size() && i < exp_addr_q.size(); i++) begin
        chk($sformatf("v%0d_addr_seq%0d", id, i), aseq[i], exp_addr_q[i]);
      end
    end
  endtask

  typedef struct {
    logic [17:0] addr;
    logic [17:0] count;
    logic [15:0] w0;
    logic [15:0] w1;
    bit          noise;
    logic [7:0]  b [4];
    int          frame_cycles;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [17:0] ra;
    int          rn;
    int          c;

    vecs[0] = '{18'h00100, 18'd1, 16'hA55A, 16'h0000, 1'b0, '{8'hA5, 8'h5A, 8'h00, 8'h00},  80};
    vecs[1] = '{18'h00040, 18'd0, 16'h0000, 16'h0000, 1'b0, '{8'h00, 8'h00, 8'h00, 8'h00},   0};
    vecs[2] = '{18'h3FFFF, 18'd2, 16'h1234, 16'h5678, 1'b0, '{8'h12, 8'h34, 8'h56, 8'h78}, 160};
    vecs[3] = '{18'h00100, 18'd1, 16'hA55A, 16'h0000, 1'b1, '{8'hA5, 8'h5A, 8'h00, 8'h00},  80};
    vecs[4] = '{18'h00010, 18'd2, 16'hBEEF, 16'h0001, 1'b0, '{8'hBE, 8'hEF, 8'h00, 8'h01}, 160};

    Resetn = 1'b0; Start = 1'b0; Start_address = '0; Word_count = '0;
    repeat (3) @(negedge Clock);
    chk("reset_sram_address", SRAM_address, 0);
    chk("reset_uart_tx", UART_TX_O, 1);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    chk("idle_uart_tx", UART_TX_O, 1);
    chk("idle_busy", Busy, 0);

    // Directed vectors
    for (int v = 0; v < 5; v++) begin
      mem[vecs[v].addr]          = vecs[v].w0;
      mem[vecs[v].addr + 18'd1]  = vecs[v].w1;
      build_model(vecs[v].addr, int'(vecs[v].count));
      exp_q.delete();
      for (int i = 0; i < 2 * int'(vecs[v].count); i++) exp_q.push_back(vecs[v].b[i]);
      run_xfer(vecs[v].addr, vecs[v].count, vecs[v].noise, vecs[v].frame_cycles, v);
    end

    // Reset during data bit 3 of the high byte, then a clean transfer
    mem[18'h00200] = 16'hC3A5;
    @(negedge Clock);
    Start = 1'b1; Start_address = 18'h00200; Word_count = 18'd1;
    @(negedge Clock);
    Start = 1'b0;
    c = 0;
    while (UART_TX_O !== 1'b0 && c < 20) begin
      @(negedge Clock);
      c++;
    end
    chk("t5_start_bit_seen", (c < 20), 1);
    repeat (4 * CPB + 1) @(negedge Clock);
    chk("t5_tx_before_reset", UART_TX_O, 0);
    #2 Resetn = 1'b0;
    #1;
    chk("t5_async_uart_tx", UART_TX_O, 1);
    chk("t5_async_busy", Busy, 0);
    chk("t5_async_addr", SRAM_address, 0);
    c = 0;
    repeat (3) begin
      @(negedge Clock);
      if (Done !== 1'b0) c++;
    end
    chk("t5_no_done_in_reset", c, 0);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    build_model(18'h00200, 1);
    run_xfer(18'h00200, 18'd1, 1'b0, 20 * CPB, 5);

    // Randomized transfers against the byte-stream model
    for (int r = 0; r < 8; r++) begin
      rn = $urandom_range(0, 3);
      ra = ($urandom_range(0, 1) == 1) ? (18'h3FFFF - 18'($urandom_range(0, 2))) : 18'($urandom);
      for (int i = 0; i < rn; i++) mem[ra + 18'(i)] = 16'($urandom);
      build_model(ra, rn);
      run_xfer(ra, 18'(rn), 1'b0, 20 * CPB * rn, 100 + r);
    end

    repeat (2) @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
